// File: rtl/ifetch_if.sv
// Fetch-stage bundle: PC register hookup, instruction-memory request/response,
// and the buffered {pc, instr} stream toward decode.
interface ifetch_if;
  logic [31:0] pc;
  logic        pc_load;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  modport slave (
    input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output pc_load, imem_req, imem_addr, out_valid, out_pc, out_instr
  );

  modport master (
    output pc, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  pc_load, imem_req, imem_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem read per PC, results queued in a
// small FIFO toward decode; flush discards in-flight and buffered fetches.
//
//   state | meaning
//   IDLE  | free to issue a request when a FIFO slot is available
//   WAIT  | one request granted, awaiting its response
//   DROP  | flushed while waiting; discard the orphaned response
module ifetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     areset,
  ifetch_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t         state_q, state_d;
  logic           req;
  logic           issue;
  logic           push;
  logic           pop;
  logic [31:0]    req_pc_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [31:0]    fifo_pc    [DEPTH];
  logic [31:0]    fifo_instr [DEPTH];

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        req = !bus.flush && (count_q != CW'(DEPTH));
        if (req && bus.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = IDLE;
          push    = !bus.flush;
        end else if (bus.flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even though the FSM sits in IDLE.
  assign bus.imem_req  = areset && req;
  assign bus.imem_addr = bus.pc;
  assign issue         = bus.imem_req && bus.imem_gnt;
  assign bus.pc_load   = areset && (issue || bus.flush);

  always_ff @(posedge clk or negedge areset) begin
    if (!areset)    req_pc_q <= '0;
    else if (issue) req_pc_q <= bus.pc;
  end

  assign pop = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (push && !bus.flush) begin
      fifo_pc[wr_ptr_q]    <= req_pc_q;
      fifo_instr[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = fifo_pc[rd_ptr_q];
  assign bus.out_instr = fifo_instr[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: PC register and memory modelled in-bench,
// returned fetches checked against a scoreboard queue.
module tb_ifetch_unit;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  ifetch_if bif();

  ifetch_unit #(.DEPTH(2)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bif)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] target = '0;
  int          lat = 1;
  bit          stray = 1'b0;
  bit          busy = 1'b0;
  bit          live = 1'b0;
  int          cnt = 0;
  logic [31:0] raddr = '0;
  int          n_grant = 0, n_load = 0, n_pop = 0;
  int          g0, l0, p0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {16'hC0DE, a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate at negedge, update PC/memory models, drive at posedge+1.
  task automatic tick();
    logic [31:0] n_pc;
    logic        rv_next;
    exp_t        e;
    @(negedge clk);
    n_pc    = bif.pc;
    rv_next = 1'b0;
    if (!areset) begin
      sbq.delete();
      busy = 1'b0;
      live = 1'b0;
    end else begin
      if (bif.pc_load) begin
        n_load++;
        n_pc = bif.flush ? target : bif.pc + 32'd4;
      end
      if (bif.flush) begin
        sbq.delete();
      end else begin
        if (bif.out_valid && bif.out_ready) begin
          n_pop++;
          tests++;
          assert (sbq.size() != 0) else begin
            fails++;
            $error("FAIL sb_pop: observed pop of pc %h expected no entry", bif.out_pc);
          end
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_out_pc", bif.out_pc, e.pc);
            chk("sb_out_instr", bif.out_instr, e.instr);
          end
        end
        if (bif.imem_rvalid && live) begin
          e.pc    = raddr;
          e.instr = memf(raddr);
          sbq.push_back(e);
        end
      end
      if (bif.flush) live = 1'b0;
      if (bif.imem_rvalid) begin
        busy = 1'b0;
        live = 1'b0;
      end else if (busy) begin
        if (cnt <= 1) rv_next = 1'b1;
        else          cnt--;
      end
      if (bif.imem_req && bif.imem_gnt) begin
        n_grant++;
        busy  = 1'b1;
        live  = 1'b1;
        raddr = bif.imem_addr;
        if (lat <= 1) rv_next = 1'b1;
        else          cnt = lat - 1;
      end
    end
    @(posedge clk);
    #1;
    bif.pc          = n_pc;
    bif.imem_rvalid = rv_next | stray;
    bif.imem_rdata  = rv_next ? memf(raddr) : 32'h0;
  endtask

  initial begin
    bif.pc = '0; bif.flush = 1'b0; bif.imem_gnt = 1'b0;
    bif.imem_rvalid = 1'b0; bif.imem_rdata = '0; bif.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_imem_req", 32'(bif.imem_req), 32'd0);
    chk("rst_pc_load", 32'(bif.pc_load), 32'd0);
    chk("rst_out_pc", bif.out_pc, 32'd0);
    chk("rst_out_instr", bif.out_instr, 32'd0);
    @(posedge clk); #1;
    areset = 1'b1; #1;
    chk("rel_imem_req", 32'(bif.imem_req), 32'd1);
    chk("rel_imem_addr", bif.imem_addr, 32'h0);

    // Stream with 1-cycle memory latency
    bif.imem_gnt = 1'b1; bif.out_ready = 1'b1; lat = 1;
    g0 = n_grant; l0 = n_load; p0 = n_pop;
    repeat (8) tick();
    #1;
    chk("stream_grants", 32'(n_grant - g0), 32'd4);
    chk("stream_load_per_grant", 32'(n_load - l0), 32'(n_grant - g0));
    chk("stream_pops", 32'(n_pop - p0), 32'd3);
    chk("stream_head_pc", bif.out_pc, 32'hC);

    // Redirect to 0, then fill the FIFO with decode stalled
    bif.flush = 1'b1; target = 32'h0; #1;
    chk("flush_pc_load", 32'(bif.pc_load), 32'd1);
    chk("flush_imem_req", 32'(bif.imem_req), 32'd0);
    tick();
    bif.flush = 1'b0; bif.out_ready = 1'b0; #1;
    chk("flush_out_valid", 32'(bif.out_valid), 32'd0);
    chk("flush_next_addr", bif.imem_addr, 32'h0);
    repeat (4) tick();
    #1;
    chk("full_imem_req", 32'(bif.imem_req), 32'd0);
    chk("full_pc_load", 32'(bif.pc_load), 32'd0);
    chk("full_head_pc", bif.out_pc, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("full_hold_req", 32'(bif.imem_req), 32'd0);
      chk("full_hold_load", 32'(bif.pc_load), 32'd0);
    end
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0; #1;
    chk("after_pop_req", 32'(bif.imem_req), 32'd1);
    chk("after_pop_addr", bif.imem_addr, 32'h8);
    chk("after_pop_head", bif.out_pc, 32'h4);
    tick(); #1;
    chk("single_wait_req", 32'(bif.imem_req), 32'd0);
    tick(); #1;
    chk("refull_req", 32'(bif.imem_req), 32'd0);
    chk("refull_valid", 32'(bif.out_valid), 32'd1);

    // Drain, then grant backpressure
    bif.imem_gnt = 1'b0; bif.out_ready = 1'b1;
    repeat (2) tick();
    #1;
    chk("drain_out_valid", 32'(bif.out_valid), 32'd0);
    chk("drain_sb_empty", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_imem_req", 32'(bif.imem_req), 32'd1);
      chk("bp_imem_addr", bif.imem_addr, 32'hC);
      chk("bp_pc_load", 32'(bif.pc_load), 32'd0);
      tick(); #1;
    end
    bif.imem_gnt = 1'b1; #1;
    chk("bp_grant_load", 32'(bif.pc_load), 32'd1);
    chk("bp_grant_addr", bif.imem_addr, 32'hC);
    tick();
    lat = 3;
    tick();

    // Flush while waiting with the response still three cycles away
    tick();
    bif.flush = 1'b1; target = 32'h100; #1;
    chk("wflush_pc_load", 32'(bif.pc_load), 32'd1);
    tick();
    bif.flush = 1'b0; #1;
    chk("drop_imem_req", 32'(bif.imem_req), 32'd0);
    chk("drop_out_valid", 32'(bif.out_valid), 32'd0);
    tick(); #1;
    chk("drop_rsp_req", 32'(bif.imem_req), 32'd0);
    tick(); #1;
    chk("post_drop_valid", 32'(bif.out_valid), 32'd0);
    chk("post_drop_req", 32'(bif.imem_req), 32'd1);
    chk("post_drop_addr", bif.imem_addr, 32'h100);

    // Flush coincident with rvalid and a pop, one entry buffered
    lat = 1; bif.out_ready = 1'b0;
    repeat (3) tick();
    #1;
    chk("f5_pre_valid", 32'(bif.out_valid), 32'd1);
    bif.out_ready = 1'b1; bif.flush = 1'b1; target = 32'h200; #1;
    chk("f5_pc_load", 32'(bif.pc_load), 32'd1);
    tick();
    bif.flush = 1'b0; #1;
    chk("f5_out_valid", 32'(bif.out_valid), 32'd0);
    chk("f5_next_addr", bif.imem_addr, 32'h200);
    p0 = n_pop;
    repeat (4) tick();
    bif.imem_gnt = 1'b0;
    repeat (3) tick();
    #1;
    chk("f5_stream_pops", 32'(n_pop - p0), 32'd2);
    chk("f5_end_valid", 32'(bif.out_valid), 32'd0);
    chk("f5_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset mid-WAIT with one buffered entry
    bif.out_ready = 1'b0; bif.imem_gnt = 1'b1; lat = 1;
    tick();
    lat = 3;
    tick();
    tick(); #1;
    chk("mid_pre_valid", 32'(bif.out_valid), 32'd1);
    areset = 1'b0; #1;
    chk("mid_rst_valid", 32'(bif.out_valid), 32'd0);
    chk("mid_rst_req", 32'(bif.imem_req), 32'd0);
    chk("mid_rst_load", 32'(bif.pc_load), 32'd0);
    chk("mid_rst_out_pc", bif.out_pc, 32'd0);
    chk("mid_rst_out_instr", bif.out_instr, 32'd0);
    bif.pc = 32'h40; bif.imem_gnt = 1'b0;
    tick();
    areset = 1'b1; #1;
    chk("mid_rel_req", 32'(bif.imem_req), 32'd1);
    chk("mid_rel_addr", bif.imem_addr, 32'h40);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick(); #1;
    chk("stray_rsp_ignored", 32'(bif.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
